// File: rtl/vseq_pkg.sv
// Shared types and constants for the vec6 evaluation sequencer.
package vseq_pkg;

    localparam int unsigned X_W   = 6;
    localparam int unsigned SIG_W = 8;
    // MISR feedback taps: bits 7, 5, 4, 3
    localparam logic [SIG_W-1:0] SIG_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/vseq_misr.sv
// 8-bit multiple-input signature register folding {f_in, x_in} into the state on each enable.
module vseq_misr
    import vseq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             f_in,
    input  logic [X_W-1:0]   x_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             fb;

    always_comb begin
        fb    = ^(sig_q & SIG_TAPS);
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], fb} ^ {{(SIG_W-X_W-1){1'b0}}, f_in, x_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/vec6_eval_sequencer.sv
// Applies programmed 6-bit patterns to the evaluation unit and records its output per pattern.
// Define VSEQ_SIG_EN to compile in the MISR signature; otherwise sig reads 8'h00.
module vec6_eval_sequencer
    import vseq_pkg::*;
#(
    parameter int unsigned  DEPTH  = 8,
    parameter int unsigned  SETTLE = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [X_W-1:0]   cfg_data,
    input  logic             start,
    input  logic [AW:0]      count,
    output logic [X_W-1:0]   x_out,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] result,
    output logic [AW:0]      ones_cnt,
    output logic [SIG_W-1:0] sig
);

    localparam logic [AW:0] DepthC  = (AW+1)'(DEPTH);
    localparam logic [3:0]  SettleC = 4'(SETTLE);

    logic [X_W-1:0] mem [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      n_q, n_d;
    logic [3:0]       wait_q, wait_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [DEPTH-1:0] result_q, result_d;
    logic [AW:0]      ones_q, ones_d;
    logic             accept;
    logic             sample;

    // Pattern memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle)) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        wait_d   = wait_q;
        x_d      = x_q;
        result_d = result_q;
        ones_d   = ones_q;
        accept   = 1'b0;
        sample   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept   = 1'b1;
                    result_d = '0;
                    ones_d   = '0;
                    idx_d    = '0;
                    wait_d   = '0;
                    n_d      = (count > DepthC) ? DepthC : count;
                    if (n_d == '0) begin
                        state_d = StDone;
                    end else begin
                        // Same-cycle write to entry 0 must be seen by this run
                        x_d     = (cfg_we && (cfg_addr == '0)) ? cfg_data : mem[0];
                        state_d = StDrive;
                    end
                end
            end
            StDrive: begin
                if (wait_q == SettleC) begin
                    state_d = StSample;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StSample: begin
                sample           = 1'b1;
                result_d[idx_q]  = f_in;
                ones_d           = ones_q + (AW+1)'(f_in);
                if ({1'b0, idx_q} == (n_q - (AW+1)'(1))) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    x_d     = mem[idx_q + AW'(1)];
                    wait_d  = '0;
                    state_d = StDrive;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            n_q      <= '0;
            wait_q   <= '0;
            x_q      <= '0;
            result_q <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            wait_q   <= wait_d;
            x_q      <= x_d;
            result_q <= result_d;
            ones_q   <= ones_d;
        end
    end

    assign x_out    = x_q;
    assign result   = result_q;
    assign ones_cnt = ones_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

`ifdef VSEQ_SIG_EN
    vseq_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (sample),
        .f_in  (f_in),
        .x_in  (x_q),
        .sig   (sig)
    );
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_vec6_eval_sequencer.sv
// Directed self-checking bench for vec6_eval_sequencer (DEPTH=8, SETTLE=1).
module tb_vec6_eval_sequencer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SETTLE = 1;
    localparam int unsigned AW     = 3;
    localparam int unsigned BOUND  = 200;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [5:0]       cfg_data;
    logic             start;
    logic [AW:0]      count;
    logic [5:0]       x_out;
    logic             f_in;
    logic             busy;
    logic             done;
    logic [DEPTH-1:0] result;
    logic [AW:0]      ones_cnt;
    logic [7:0]       sig;

    logic             f_sel;
    int               n_checks;
    int               n_fail;
    int               cyc;
    logic [7:0]       exp_sig;

    // f_sel=1: unit modelled as OUT = X1; f_sel=0: OUT tied high
    assign f_in = f_sel ? x_out[0] : 1'b1;

    vec6_eval_sequencer #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .count    (count),
        .x_out    (x_out),
        .f_in     (f_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ones_cnt (ones_cnt),
        .sig      (sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [5:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Pulse start, then count cycles until done is seen (cyc=1 right after the accept edge).
    task automatic run(input logic [AW:0] c, output int lat);
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < BOUND) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        start    = 1'b0;
        count    = '0;
        f_sel    = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ones", ones_cnt, 0);
        check("rst_sig", sig, 0);
        #2 rst_n = 1'b1;
        tick();

        wr(3'd0, 6'h29);
        wr(3'd1, 6'h2C);
        wr(3'd2, 6'h29);
        wr(3'd3, 6'h01);
        wr(3'd4, 6'h00);
        wr(3'd5, 6'h03);
        wr(3'd6, 6'h3E);
        wr(3'd7, 6'h15);

        // Three patterns, OUT = X1
        count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);
        check("first_x", x_out, 6'h29);
        cyc = 1;
        while (!done && cyc < BOUND) begin
            tick();
            cyc++;
        end
        check("lat_n3", cyc, 3 * (SETTLE + 2) + 1);
        check("result_n3", result, 8'b0000_0101);
        check("ones_n3", ones_cnt, 2);
        check("x_hold_n3", x_out, 6'h29);
        tick();
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);

        // count = 0
        run(4'd0, cyc);
        check("lat_n0", cyc, 1);
        check("result_n0", result, 0);
        check("ones_n0", ones_cnt, 0);
        check("x_keep_n0", x_out, 6'h29);
        tick();

        // count clamped to DEPTH
        run(4'd15, cyc);
        check("lat_clamp", cyc, DEPTH * (SETTLE + 2) + 1);
        check("result_clamp", result, 8'hAD);
        check("ones_clamp", ones_cnt, 5);
        check("x_last_clamp", x_out, 6'h15);
        tick();

        // Write and start while busy are ignored
        count = 4'd2;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        tick();
        cyc++;
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 6'h3F;
        start    = 1'b1;
        tick();
        cyc++;
        cfg_we = 1'b0;
        start  = 1'b0;
        while (!done && cyc < BOUND) begin
            tick();
            cyc++;
        end
        check("lat_busy_poke", cyc, 2 * (SETTLE + 2) + 1);
        tick();
        tick();
        check("no_extra_run", busy, 0);
        run(4'd1, cyc);
        check("mem_unchanged_x", x_out, 6'h29);
        check("mem_unchanged_r", result, 1);
        tick();

        // Same-cycle write and start in IDLE
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 6'h3E;
        count    = 4'd1;
        start    = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        check("wr_start_x", x_out, 6'h3E);
        cyc = 1;
        while (!done && cyc < BOUND) begin
            tick();
            cyc++;
        end
        check("wr_start_lat", cyc, SETTLE + 3);
        check("wr_start_res", result, 0);
        tick();
        wr(3'd0, 6'h29);

        // Signature, one pattern 0x29 with OUT = 1
        f_sel = 1'b0;
        run(4'd1, cyc);
`ifdef VSEQ_SIG_EN
        exp_sig = 8'h69;
`else
        exp_sig = 8'h00;
`endif
        check("sig_one", sig, exp_sig);
        check("sig_res", result, 1);
        check("sig_ones", ones_cnt, 1);
        tick();

        // Reset during DRIVE of pattern 2
        count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_x", x_out, 6'h2C);
        check("pre_rst_ones", ones_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_x", x_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_ones", ones_cnt, 0);
        check("arst_sig", sig, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        tick();
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
